// File: rtl/iob_cache_write_buffer.sv
// Write-through buffer: queues cache word writes and drains them in order to memory via req/ack.
// Optional same-address write merging into the newest entry: define IOB_CACHE_WB_MERGE_EN.
module iob_cache_write_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              wr_req_i,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]                 wr_wdata_i,
  input  logic [DATA_W/8-1:0]               wr_wstrb_i,
  output logic                              wr_full_o,
  output logic                              wr_empty_o,
  output logic [DEPTH_W:0]                  wr_level_o,
  output logic                              mem_req_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  output logic [DATA_W/8-1:0]               mem_wstrb_o,
  input  logic                              mem_ack_i
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int WADDR_W = ADDR_W - OFF_W;
  localparam int DEPTH   = 1 << DEPTH_W;

  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W + 1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e               state_q, state_d;
  logic [WADDR_W-1:0]   addr_mem [DEPTH];
  logic [DATA_W-1:0]    data_mem [DEPTH];
  logic [STRB_W-1:0]    strb_mem [DEPTH];
  logic [DEPTH_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_W:0]     level_q, level_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]    mem_wstrb_q, mem_wstrb_d;
  logic                 push, pop, merge;

`ifdef IOB_CACHE_WB_MERGE_EN
  logic [DEPTH_W-1:0]   tail;

  // With fewer than two entries the newest one is (or is about to be) loaded into REQ.
  assign tail  = wptr_q - PTR_ONE;
  assign merge = wr_req_i && (level_q >= (DEPTH_W + 1)'(2)) && (addr_mem[tail] == wr_addr_i);
`else
  assign merge = 1'b0;
`endif

  assign wr_full_o  = (level_q == LVL_FULL);
  assign wr_empty_o = (level_q == '0) && (state_q == IDLE);
  assign wr_level_o = level_q;
  assign push       = wr_req_i && !merge && !wr_full_o;
  assign pop        = (state_q == REQ) && mem_ack_i;

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = ADDR_W'(addr_mem[rptr_q]) << OFF_W;
          mem_wdata_d = data_mem[rptr_q];
          mem_wstrb_d = strb_mem[rptr_q];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          rptr_d    = rptr_q + PTR_ONE;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push ? (wptr_q + PTR_ONE) : wptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Storage is not reset: slots are only read once the level says they hold valid data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wptr_q] <= wr_addr_i;
      data_mem[wptr_q] <= wr_wdata_i;
      strb_mem[wptr_q] <= wr_wstrb_i;
    end
`ifdef IOB_CACHE_WB_MERGE_EN
    else if (merge) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_wstrb_i[b]) begin
          data_mem[tail][b*8 +: 8] <= wr_wdata_i[b*8 +: 8];
          strb_mem[tail][b]        <= 1'b1;
        end
      end
    end
`endif
  end

endmodule

// File: doc/iob_cache_write_buffer.md
Name: iob_cache_write_buffer

Overview:
- Write-through buffer between the cache front-end and back-end memory.
- The cache pushes word writes (address, data, byte strobes) into a FIFO.
- The block drains entries in order to the back-end native memory interface with a req/ack handshake.
- The cache uses `wr_empty` to stall read misses until pending writes are committed, which avoids RAW hazards.

Parameters:
- ADDR_W, 32, byte-address width on the memory side.
- DATA_W, 32, data word width; a multiple of 8.
- DEPTH_W, 2, log2 of FIFO depth; 2^DEPTH_W entries, DEPTH_W >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_req  in  1  push request from cache, one cycle per entry.
- wr_addr  in  ADDR_W-$clog2(DATA_W/8)  word address.
- wr_wdata  in  DATA_W  write data.
- wr_wstrb  in  DATA_W/8  byte enables; must be nonzero when wr_req=1.
- wr_full  out  1  FIFO full; push ignored while high.
- wr_empty  out  1  FIFO empty and no transfer outstanding.
- wr_level  out  DEPTH_W+1  occupancy, 0..2^DEPTH_W.
- mem_req  out  1  memory write request.
- mem_addr  out  ADDR_W  byte address = {head word address, $clog2(DATA_W/8) zeros}.
- mem_wdata  out  DATA_W  head data.
- mem_wstrb  out  DATA_W/8  head strobes.
- mem_ack  in  1  memory accepted the current write, single-cycle pulse.

Behaviour:
- Reset, asynchronous while reset=0:
  - FIFO pointers and level cleared.
  - FSM goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - wr_full=0, wr_empty=1, wr_level=0.
  - Reset in the middle of a transfer drops mem_req immediately, discards the entry, and ignores any later mem_ack.
- Push:
  - Entry written at a clock edge when wr_req=1 and wr_full=0.
  - wr_req while wr_full=1 is dropped. The cache must hold its request until wr_full=0; the block does not retry.
- Push and pop in the same edge: both occur and the level is unchanged.
  - A push into a full FIFO is not allowed even if a pop happens in that cycle; wr_full is registered.
- Pointers wrap modulo 2^DEPTH_W. wr_full = (level == 2^DEPTH_W).
- FSM, all outputs registered:
  - IDLE: if level>0, load head into mem_addr/mem_wdata/mem_wstrb, set mem_req=1, go to REQ.
  - REQ: hold mem_req and all mem_* outputs stable until mem_ack=1. On that edge, pop the head, set mem_req=0, go to IDLE.
  - An entry therefore takes at least 2 cycles, so mem_req always shows a one-cycle low gap between entries.
  - mem_ack while in IDLE is ignored.
- Latency: push at edge N into an empty buffer → mem_req=1 after edge N+1.
- wr_empty=1 only when level==0 and the FSM is in IDLE. It goes to 0 at the push edge and returns to 1 at the ack edge of the last entry.
- Entries drain in strict FIFO order. Data and strobes pass through unmodified, except as described under Optional Feature.

Optional Feature:
- Macro: IOB_CACHE_WB_MERGE_EN.
- When defined: a push whose wr_addr equals the most recently pushed entry is merged into that entry instead of allocating a new slot, provided the entry is still in the FIFO and not loaded into REQ.
  - Merge rule: for each byte with wr_wstrb=1, overwrite the data byte and set the strobe bit.
  - Level is unchanged, and the merge is accepted even when wr_full=1.
- When not defined: every accepted push allocates a new entry.

Test Plan:
1. Reset release, then push addr=0x1, wdata=0x3, wstrb=0xF, with mem_ack 2 cycles after mem_req → mem_req rises one edge after the push; mem_addr=0x4, mem_wdata=0x3, mem_wstrb=0xF; after the ack, wr_empty=1 and wr_level=0.
2. Push 4 entries (addr i, wdata i*3, i=0..3) with mem_ack held low → wr_full=1 and wr_level=4; a 5th push is dropped; releasing ack drains 0,0x3,0x6,0x9 in order, with a one-cycle low gap in mem_req between entries.
3. Simultaneous push and ack-pop at level 2 → level stays at 2 and order is preserved.
4. Assert reset (0) while mem_req=1 → mem_req=0 immediately, wr_empty=1, and a late mem_ack has no effect.
5. With IOB_CACHE_WB_MERGE_EN, while the FSM is in REQ with another entry (addr 5) ahead: push addr=7, wdata=0x000000AA, wstrb=0x1, then addr=7, wdata=0xBB000000, wstrb=0x8 → level grows by 1 only; drained entry has wdata=0xBB0000AA, wstrb=0x9. Without the macro → two separate entries.
6. mem_ack pulse while IDLE and empty → no pop, level stays 0, no X on outputs.
